// File: rtl/nn_infer_sched_pkg.sv
// Shared types and default constants for the inference scheduler.
package nn_infer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH     = 16;
  localparam int unsigned DEF_NUM_INPUTS     = 784;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 65535;

endpackage

// File: rtl/nn_infer_sched_if.sv
// Stream, network-result and status signals of the inference scheduler.
interface nn_infer_sched_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] l1_data;
  logic                  l1_valid;
  logic                  net_valid;
  logic [31:0]           net_class;
  logic [31:0]           result;
  logic                  done;
  logic                  busy;
  logic                  err_clr;
  logic                  timeout_err;
  logic [15:0]           infer_count;

  modport slave (
    input  in_data, in_valid, net_valid, net_class, err_clr,
    output in_ready, l1_data, l1_valid, result, done, busy, timeout_err, infer_count
  );

  modport master (
    output in_data, in_valid, net_valid, net_class, err_clr,
    input  in_ready, l1_data, l1_valid, result, done, busy, timeout_err, infer_count
  );
endinterface

// File: rtl/nn_infer_sched.sv
// Inference scheduler: streams NUM_INPUTS samples to layer 1, then waits for the classifier.
// Optional WAIT watchdog enabled by defining NN_SCHED_TIMEOUT_EN.
module nn_infer_sched
  import nn_infer_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned NUM_INPUTS     = DEF_NUM_INPUTS,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              s_axi_aclk,
  input  logic              reset,
  nn_infer_sched_if.slave   bus
);

  localparam int unsigned CW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] l1_data_q, l1_data_d;
  logic                  l1_valid_q, l1_valid_d;
  logic [31:0]           result_q, result_d;
  logic                  done_q, done_d;
  logic [15:0]           infer_q, infer_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  accept;

`ifdef NN_SCHED_TIMEOUT_EN
  localparam int unsigned WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WW-1:0] wait_q, wait_d;
  logic          terr_q, terr_d;
  logic          timeout_fire;
`endif

  assign accept = bus.in_valid & in_ready_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    l1_valid_d = accept;
    l1_data_d  = accept ? bus.in_data : l1_data_q;
    result_d   = result_q;
    done_d     = 1'b0;
    infer_d    = infer_q;
`ifdef NN_SCHED_TIMEOUT_EN
    wait_d       = '0;
    timeout_fire = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (NUM_INPUTS == 1) begin
            state_d = WAIT;
            cnt_d   = '0;
          end else begin
            state_d = STREAM;
            cnt_d   = CW'(1);
          end
        end
      end
      STREAM: begin
        if (accept) begin
          if (cnt_q == CW'(NUM_INPUTS - 1)) begin
            state_d = WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WAIT: begin
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (bus.net_valid) begin
          result_d = bus.net_class;
          done_d   = 1'b1;
          infer_d  = infer_q + 16'd1;
          state_d  = IDLE;
        end
`ifdef NN_SCHED_TIMEOUT_EN
        else if (wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
          timeout_fire = 1'b1;
          state_d      = IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef NN_SCHED_TIMEOUT_EN
    if (timeout_fire)     terr_d = 1'b1;
    else if (bus.err_clr) terr_d = 1'b0;
    else                  terr_d = terr_q;
`endif
    in_ready_d = (state_d != WAIT);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      l1_data_q  <= '0;
      l1_valid_q <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      infer_q    <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
`ifdef NN_SCHED_TIMEOUT_EN
      wait_q     <= '0;
      terr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      l1_data_q  <= l1_data_d;
      l1_valid_q <= l1_valid_d;
      result_q   <= result_d;
      done_q     <= done_d;
      infer_q    <= infer_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
`ifdef NN_SCHED_TIMEOUT_EN
      wait_q     <= wait_d;
      terr_q     <= terr_d;
`endif
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.l1_data     = l1_data_q;
  assign bus.l1_valid    = l1_valid_q;
  assign bus.result      = result_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.infer_count = infer_q;

`ifdef NN_SCHED_TIMEOUT_EN
  assign bus.timeout_err = terr_q;
`else
  logic unused_err_clr;
  assign unused_err_clr  = bus.err_clr;
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_nn_infer_sched.sv
// Directed self-checking bench for nn_infer_sched (NUM_INPUTS=4, TIMEOUT_CYCLES=8).
module tb_nn_infer_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_infer = 0;
  int unsigned pulses;

  always #5 clk = ~clk;

  nn_infer_sched_if #(.DATA_WIDTH(16)) bus ();

  nn_infer_sched #(
    .DATA_WIDTH    (16),
    .NUM_INPUTS    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .s_axi_aclk(clk),
    .reset     (rst),
    .bus       (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Four contiguous beats first..first+3; WAIT is entered on the last one.
  task automatic send_beats(input logic [15:0] first);
    for (int unsigned i = 0; i < 4; i++) begin
      check("pre_in_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = first + 16'(i);
      tick();
      check("beat_l1_valid", 32'(bus.l1_valid), 32'd1);
      check("beat_l1_data", 32'(bus.l1_data), 32'(first + 16'(i)));
    end
    bus.in_valid = 1'b0;
    check("wait_in_ready", 32'(bus.in_ready), 32'd0);
    check("wait_busy", 32'(bus.busy), 32'd1);
  endtask

  task automatic complete(input logic [31:0] cls);
    bus.net_valid = 1'b1;
    bus.net_class = cls;
    tick();
    bus.net_valid = 1'b0;
    exp_infer++;
    check("cmp_done", 32'(bus.done), 32'd1);
    check("cmp_result", bus.result, cls);
    check("cmp_infer", 32'(bus.infer_count), exp_infer);
    check("cmp_busy", 32'(bus.busy), 32'd0);
    check("cmp_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.net_valid = 1'b0;
    bus.net_class = '0;
    bus.err_clr   = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_l1_valid", 32'(bus.l1_valid), 32'd0);
    check("rst_l1_data", 32'(bus.l1_data), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_terr", 32'(bus.timeout_err), 32'd0);
    check("rst_infer", 32'(bus.infer_count), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Contiguous stream then completion with class 7
    send_beats(16'd1);
    tick();
    check("post_l1_valid", 32'(bus.l1_valid), 32'd0);
    complete(32'd7);
    tick();
    check("done_one_cycle", 32'(bus.done), 32'd0);

    // net_valid in IDLE is ignored
    bus.net_valid = 1'b1;
    bus.net_class = 32'd99;
    tick();
    bus.net_valid = 1'b0;
    check("idle_nv_done", 32'(bus.done), 32'd0);
    check("idle_nv_result", bus.result, 32'd7);
    check("idle_nv_infer", 32'(bus.infer_count), 32'd1);

    // Gapped stream: exactly four forwarded beats
    pulses = 0;
    for (int unsigned k = 0; k < 7; k++) begin
      bus.in_valid = pat[k];
      bus.in_data  = 16'h10 + 16'(k);
      tick();
      check("gap_l1_valid", 32'(bus.l1_valid), 32'(pat[k]));
      if (pat[k]) check("gap_l1_data", 32'(bus.l1_data), 32'h10 + k);
      pulses += 32'(bus.l1_valid);
    end
    check("gap_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_data = 16'hFF;
    for (int unsigned k = 0; k < 2; k++) begin
      tick();
      check("wait_no_fwd", 32'(bus.l1_valid), 32'd0);
      pulses += 32'(bus.l1_valid);
    end
    bus.in_valid = 1'b0;
    check("gap_pulses", pulses, 32'd4);
    complete(32'h55);

`ifdef NN_SCHED_TIMEOUT_EN
    // Watchdog expiry after 8 WAIT cycles
    send_beats(16'h20);
    for (int unsigned k = 0; k < 7; k++) begin
      tick();
      check("to_pending", 32'(bus.timeout_err), 32'd0);
      check("to_busy", 32'(bus.busy), 32'd1);
    end
    tick();
    check("to_err", 32'(bus.timeout_err), 32'd1);
    check("to_busy_end", 32'(bus.busy), 32'd0);
    check("to_done", 32'(bus.done), 32'd0);
    check("to_result", bus.result, 32'h55);
    check("to_infer", 32'(bus.infer_count), exp_infer);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("clr_err", 32'(bus.timeout_err), 32'd0);

    // New timeout wins over simultaneous err_clr
    send_beats(16'h30);
    bus.err_clr = 1'b1;
    for (int unsigned k = 0; k < 8; k++) tick();
    bus.err_clr = 1'b0;
    check("to_vs_clr", 32'(bus.timeout_err), 32'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("clr_err2", 32'(bus.timeout_err), 32'd0);

    // net_valid on the expiry cycle counts as completion
    send_beats(16'h40);
    for (int unsigned k = 0; k < 7; k++) tick();
    complete(32'h33);
    check("edge_no_terr", 32'(bus.timeout_err), 32'd0);
`else
    // Without the watchdog WAIT holds indefinitely
    send_beats(16'h20);
    for (int unsigned k = 0; k < 20; k++) tick();
    check("hold_busy", 32'(bus.busy), 32'd1);
    check("hold_terr", 32'(bus.timeout_err), 32'd0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("hold_busy2", 32'(bus.busy), 32'd1);
    complete(32'h33);
    check("no_terr", 32'(bus.timeout_err), 32'd0);
`endif

    // Reset after beat 2 abandons the inference
    tick();
    for (int unsigned i = 1; i <= 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(i);
      tick();
    end
    bus.in_data = 16'd3;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    exp_infer = 0;
    check("mrst_l1_valid", 32'(bus.l1_valid), 32'd0);
    check("mrst_l1_data", 32'(bus.l1_data), 32'd0);
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_result", bus.result, 32'd0);
    check("mrst_infer", 32'(bus.infer_count), 32'd0);
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    send_beats(16'd5);
    complete(32'h21);

    // Back-to-back inference straight after the done pulse
    send_beats(16'd9);
    complete(32'h22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_infer_sched.md
NN_INFER_SCHED -- requirements
Module: nn_infer_sched

Interface
- REQ-001: Parameter DATA_WIDTH, default 16; width of one input sample.
- REQ-002: Parameter NUM_INPUTS, default 784; samples per inference (layer-1 weight count).
- REQ-003: Parameter TIMEOUT_CYCLES, default 65535; maximum WAIT-state cycles before abort.
- REQ-004: s_axi_aclk  in  1  clock; all logic is rising-edge.
- REQ-005: reset  in  1  synchronous, active-high reset (AXI reset inverted OR soft reset).
- REQ-006: in_data  in  DATA_WIDTH  input stream sample.
- REQ-007: in_valid  in  1  sample valid.
- REQ-008: in_ready  out  1  sample accepted when in_valid&in_ready.
- REQ-009: l1_data  out  DATA_WIDTH  sample forwarded to layer 1.
- REQ-010: l1_valid  out  1  forwarded-sample strobe.
- REQ-011: net_valid  in  1  final-layer classifier result strobe.
- REQ-012: net_class  in  32  classifier result.
- REQ-013: result  out  32  last captured class.
- REQ-014: done  out  1  one-cycle completion pulse (interrupt source).
- REQ-015: busy  out  1  high in STREAM or WAIT.
- REQ-016: err_clr  in  1  clears timeout_err.
- REQ-017: timeout_err  out  1  sticky timeout flag.
- REQ-018: infer_count  out  16  completed inferences, wraps 0xFFFF->0.

Function
- REQ-019: States IDLE, STREAM, WAIT; in_ready = 1 in IDLE and STREAM, 0 in WAIT.
- REQ-020: Accepted beat is registered to l1_data with l1_valid high exactly one cycle later; no other cycle asserts l1_valid.
- REQ-021: IDLE + accepted beat -> sample count = 1, next state STREAM (WAIT if NUM_INPUTS == 1).
- REQ-022: STREAM: each accepted beat increments count; beat NUM_INPUTS moves to WAIT, count cleared; in_ready drops the cycle after that beat.
- REQ-023: Gaps in in_valid during STREAM are allowed; state and count hold.
- REQ-024: WAIT + net_valid -> result <= net_class, done pulses next cycle, infer_count increments, state IDLE.
- REQ-025: net_valid in IDLE or STREAM is ignored; result, done, infer_count unchanged.
- REQ-026: WAIT cycle counter starts at 0 on entry; reaching TIMEOUT_CYCLES without net_valid sets timeout_err, returns to IDLE, no done, result unchanged.
- REQ-027: net_valid on the same cycle as timeout expiry is treated as completion; timeout_err not set.
- REQ-028: err_clr clears timeout_err next cycle; a simultaneous new timeout wins (flag stays set).
- REQ-029: done must be able to follow back-to-back inferences with no dead cycle besides WAIT.

Reset
- REQ-030: On reset: state IDLE, counts 0, l1_valid 0, l1_data 0, done 0, result 0, timeout_err 0, infer_count 0.
- REQ-031: Reset mid-STREAM or mid-WAIT abandons the inference; any pending l1_valid is suppressed the following cycle.

Configuration
- REQ-032: Macro NN_SCHED_TIMEOUT_EN defined: REQ-026..028 active.
- REQ-033: NN_SCHED_TIMEOUT_EN undefined: no WAIT counter, WAIT holds until net_valid, timeout_err tied 0, err_clr ignored.

Structure
- REQ-034: Shared package holds the state encoding (2-bit enum IDLE=0, STREAM=1, WAIT=2) and default constants for NUM_INPUTS and TIMEOUT_CYCLES.
- REQ-035: Single flat module; no sub-modules.

Verification
- REQ-036: NUM_INPUTS=4, four contiguous beats 1..4 -> l1_data 1..4 each one cycle later, in_ready 0 after beat 4, busy 1.
- REQ-037: WAIT, net_valid with net_class=7 -> result=7, one-cycle done, infer_count=1, state IDLE, in_ready 1.
- REQ-038: Beats with in_valid gaps (valid 1,0,0,1...) -> exactly NUM_INPUTS l1_valid pulses, no duplicates.
- REQ-039: TIMEOUT_CYCLES=8, no net_valid -> timeout_err=1 after 8 WAIT cycles, no done; err_clr -> timeout_err=0.
- REQ-040: Reset asserted after beat 2 of 4 -> all outputs at reset values; next 4 beats complete a fresh inference.
- REQ-041: net_valid pulsed in IDLE -> result and infer_count unchanged, done stays 0.
